pad_oe_sequencer: RTL and testbench
===================================

# pad_oe_sequencer

Sequencing controller for a bank of `pad_cell_output` instances. It takes one pad-configuration request at a time, applies the new pad attributes, and disables pads immediately. After a settle interval, it re-enables pad output-enables one pad at a time with a programmable stagger, which limits simultaneous-switching noise on the pad ring. It sits between the pad-control register file and the pad ring, and drives `pad_oe_i` and `pad_attributes_i` of each pad.

## Interface
- `NPADS`, 8: number of pads controlled (1..32).
- `PADATTR`, 16: attribute width per pad; matches pad-cell attribute width.
- `SETTLE_CYCLES`, 2: cycles between attribute update and first enable (≥1).
- `STAGGER_CYCLES`, 3: wait cycles after each pad enable (≥1).
- `RESET_ATTR`, '0: attribute value of every pad after reset.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `cfg_valid_i` in 1: configuration request valid.
- `cfg_ready_o` out 1: controller idle and able to accept a request.
- `cfg_attr_i` in PADATTR: attribute value broadcast to the selected pads.
- `cfg_attr_we_i` in NPADS: per-pad attribute write enable.
- `cfg_oe_mask_i` in NPADS: target output-enable state per pad.
- `abort_i` in 1: abort the sequence and force all pads disabled.
- `pad_oe_o` out NPADS: per-pad output enable.
- `pad_attributes_o` out NPADS*PADATTR: pad i attributes at `[i*PADATTR +: PADATTR]`.
- `busy_o` out 1: high in any state other than IDLE.
- `done_o` out 1: one-cycle pulse when a sequence completes.

## Operation
- States: IDLE, APPLY, SETTLE, ENABLE, WAIT, DONE.
- `cfg_ready_o` = (state == IDLE), combinational. A request is accepted on an edge with `cfg_valid_i && cfg_ready_o`. The request is latched and the state goes to APPLY.
- APPLY (one cycle):
  - For each pad with `cfg_attr_we_i[i]`, attribute ← `cfg_attr_i`.
  - `pad_oe_o` ← `pad_oe_o & mask`, so disables take effect immediately.
  - Settle counter ← SETTLE_CYCLES−1; state → SETTLE.
- SETTLE: counter decrements each cycle. At 0, go to ENABLE with index ← 0.
- ENABLE at index i: a pad needs enabling when `mask[i] && !pad_oe_o[i]`.
  - If pad i needs enabling: set `pad_oe_o[i]`, stagger counter ← STAGGER_CYCLES−1, state → WAIT.
  - Otherwise: if i == NPADS−1, go to DONE; else index ← i+1 and stay in ENABLE.
- WAIT: counter decrements each cycle. At 0: if index == NPADS−1, go to DONE; else index+1 and go to ENABLE.
- DONE: `done_o` = 1 for exactly one cycle, then IDLE.
- Pads are enabled in ascending index order. Pads already enabled are never toggled.
- `abort_i` in any non-IDLE state: next edge sets `pad_oe_o` to all 0 and returns to IDLE. There is no `done_o`. Attributes already written are kept.
- `abort_i` in IDLE is ignored.
- `abort_i` coincident with acceptance: abort wins; the request is dropped and all pads are disabled.
- Requests arriving while busy are not accepted (`cfg_ready_o` = 0). The requester holds `cfg_valid_i`.
- The index counter is clog2(NPADS) bits wide (minimum 1) and never wraps past NPADS−1.

## Timing
- Reset values:
  - `pad_oe_o` = 0.
  - `pad_attributes_o` = RESET_ATTR for every pad.
  - `busy_o` = 0, `done_o` = 0.
  - `cfg_ready_o` = 1 once `rst_i` is low.
- Reset mid-sequence returns all of the above to reset values on the same edge.
- Timeline for acceptance at edge E0:
  - Attributes and disables are visible after E1.
  - The first pad enable is visible after edge E1+SETTLE_CYCLES+1.
- Spacing between consecutive enables = STAGGER_CYCLES + 1 + (number of skipped indices).
- `done_o` is high for the cycle after the DONE entry edge. `cfg_ready_o` returns to 1 the cycle after that.
- All outputs are registered except `cfg_ready_o`.

## Configuration
- `PAD_OE_STAGGER_EN`:
  - Defined: staggered per-pad enable, as described above.
  - Undefined: WAIT is never entered. The first ENABLE cycle sets `pad_oe_o |= mask` for all pads on one edge, then goes to DONE. The `STAGGER_CYCLES` parameter is ignored.

## Test plan
- Reset → `pad_oe_o`=0, all attributes = RESET_ATTR, `cfg_ready_o`=1, `busy_o`=0.
- NPADS=4, SETTLE=2, STAGGER=3, all pads off; accept at E0 with mask 0101, attr 0x00A5, we 1111:
  - All four attributes = 0x00A5 after E1.
  - `pad_oe_o[0]` rises after E4.
  - `pad_oe_o[2]` rises after E9.
  - `done_o` pulses exactly once.
- Starting from `pad_oe_o`=1111, request mask 0011 → bits 3:2 drop after E1, bits 1:0 are never toggled, `done_o` pulses, no enable edges occur.
- Abort during WAIT after pad0 is enabled → `pad_oe_o`=0000 on the next edge, IDLE, `done_o` stays 0.
- `cfg_valid_i` held high while busy → a second request is accepted only on the edge after `done_o`; `rst_i` asserted in SETTLE → reset values on the next edge.
- Without `PAD_OE_STAGGER_EN`, mask 1011 → bits 0, 1 and 3 rise on the same edge, after E4.

Source files
------------

// File: rtl/pad_oe_sequencer.sv
// Pad-ring output-enable sequencer: applies pad attributes, disables pads at once, then re-enables them after a settle delay.
// Build option PAD_OE_STAGGER_EN: staggered one-pad-at-a-time enables; when undefined, all masked pads enable on one edge.
module pad_oe_sequencer #(
    parameter int unsigned        NPADS          = 8,
    parameter int unsigned        PADATTR        = 16,
    parameter int unsigned        SETTLE_CYCLES  = 2,
    parameter int unsigned        STAGGER_CYCLES = 3,
    parameter logic [PADATTR-1:0] RESET_ATTR     = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cfg_valid_i,
    output logic                     cfg_ready_o,
    input  logic [PADATTR-1:0]       cfg_attr_i,
    input  logic [NPADS-1:0]         cfg_attr_we_i,
    input  logic [NPADS-1:0]         cfg_oe_mask_i,
    input  logic                     abort_i,
    output logic [NPADS-1:0]         pad_oe_o,
    output logic [NPADS*PADATTR-1:0] pad_attributes_o,
    output logic                     busy_o,
    output logic                     done_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_ENABLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    // One down-counter serves both the settle and the stagger intervals.
    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > STAGGER_CYCLES) ? SETTLE_CYCLES : STAGGER_CYCLES;
    localparam int unsigned CNTW    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNTW-1:0] SETTLE_LOAD = CNTW'(SETTLE_CYCLES - 1);

`ifdef PAD_OE_STAGGER_EN
    localparam int unsigned     IDXW         = (NPADS > 1) ? $clog2(NPADS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX     = IDXW'(NPADS - 1);
    localparam logic [CNTW-1:0] STAGGER_LOAD = CNTW'(STAGGER_CYCLES - 1);

    logic [IDXW-1:0] idx, idx_next;
    logic            need;
    logic            last;
`endif

    state_t                   state, state_next;
    logic [CNTW-1:0]          cnt, cnt_next;
    logic [PADATTR-1:0]       req_attr, req_attr_next;
    logic [NPADS-1:0]         req_we, req_we_next;
    logic [NPADS-1:0]         req_mask, req_mask_next;
    logic [NPADS-1:0]         oe_next;
    logic [NPADS*PADATTR-1:0] attr_next;
    logic                     done_next;
    logic                     busy_next;

    assign cfg_ready_o = (state == ST_IDLE);

`ifdef PAD_OE_STAGGER_EN
    assign need = req_mask[idx] && !pad_oe_o[idx];
    assign last = (idx == LAST_IDX);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            req_attr         <= '0;
            req_we           <= '0;
            req_mask         <= '0;
            pad_oe_o         <= '0;
            pad_attributes_o <= {NPADS{RESET_ATTR}};
            done_o           <= 1'b0;
            busy_o           <= 1'b0;
`ifdef PAD_OE_STAGGER_EN
            idx              <= '0;
`endif
        end else begin
            state            <= state_next;
            cnt              <= cnt_next;
            req_attr         <= req_attr_next;
            req_we           <= req_we_next;
            req_mask         <= req_mask_next;
            pad_oe_o         <= oe_next;
            pad_attributes_o <= attr_next;
            done_o           <= done_next;
            busy_o           <= busy_next;
`ifdef PAD_OE_STAGGER_EN
            idx              <= idx_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cfg_valid_i && !abort_i) begin
                    state_next = ST_APPLY;
                end
            end
            ST_APPLY: state_next = ST_SETTLE;
            ST_SETTLE: begin
                if (cnt == '0) begin
                    state_next = ST_ENABLE;
                end
            end
            ST_ENABLE: begin
`ifdef PAD_OE_STAGGER_EN
                if (need) begin
                    state_next = ST_WAIT;
                end else if (last) begin
                    state_next = ST_DONE;
                end
`else
                state_next = ST_DONE;
`endif
            end
            ST_WAIT: begin
`ifdef PAD_OE_STAGGER_EN
                if (cnt == '0) begin
                    state_next = last ? ST_DONE : ST_ENABLE;
                end
`else
                state_next = ST_IDLE;
`endif
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (abort_i && state != ST_IDLE) begin
            state_next = ST_IDLE;
        end
    end

    always_comb begin
        oe_next       = pad_oe_o;
        attr_next     = pad_attributes_o;
        cnt_next      = cnt;
        req_attr_next = req_attr;
        req_we_next   = req_we;
        req_mask_next = req_mask;
`ifdef PAD_OE_STAGGER_EN
        idx_next      = idx;
`endif
        case (state)
            ST_IDLE: begin
                // An abort coincident with a request drops the request but still disables every pad.
                if (cfg_valid_i) begin
                    if (abort_i) begin
                        oe_next = '0;
                    end else begin
                        req_attr_next = cfg_attr_i;
                        req_we_next   = cfg_attr_we_i;
                        req_mask_next = cfg_oe_mask_i;
                    end
                end
            end
            ST_APPLY: begin
                for (int unsigned i = 0; i < NPADS; i++) begin
                    if (req_we[i]) begin
                        attr_next[i*PADATTR +: PADATTR] = req_attr;
                    end
                end
                oe_next  = pad_oe_o & req_mask;
                cnt_next = SETTLE_LOAD;
            end
            ST_SETTLE: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CNTW'(1);
                end
`ifdef PAD_OE_STAGGER_EN
                else begin
                    idx_next = '0;
                end
`endif
            end
            ST_ENABLE: begin
`ifdef PAD_OE_STAGGER_EN
                if (need) begin
                    oe_next[idx] = 1'b1;
                    cnt_next     = STAGGER_LOAD;
                end else if (!last) begin
                    idx_next = idx + IDXW'(1);
                end
`else
                oe_next = pad_oe_o | req_mask;
`endif
            end
            ST_WAIT: begin
`ifdef PAD_OE_STAGGER_EN
                if (cnt != '0) begin
                    cnt_next = cnt - CNTW'(1);
                end else if (!last) begin
                    idx_next = idx + IDXW'(1);
                end
`endif
            end
            default: ;
        endcase
        if (abort_i && state != ST_IDLE) begin
            oe_next = '0;
        end
        done_next = (state_next == ST_DONE);
        busy_next = (state_next != ST_IDLE);
    end

endmodule

// File: tb/tb_pad_oe_sequencer.sv
// Scoreboard bench for pad_oe_sequencer: per-cycle expectations derived from the documented timeline, both build options.
module tb_pad_oe_sequencer;

    localparam int NP      = 4;
    localparam int PA      = 16;
    localparam int SETTLE  = 2;
    localparam int STAGGER = 3;
    localparam logic [15:0] RATTR = 16'hC33C;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [15:0]   cfg_attr;
    logic [3:0]    cfg_we;
    logic [3:0]    cfg_mask;
    logic          abort;
    logic [3:0]    pad_oe;
    logic [63:0]   pad_attr;
    logic          busy;
    logic          done;

    pad_oe_sequencer #(
        .NPADS(NP),
        .PADATTR(PA),
        .SETTLE_CYCLES(SETTLE),
        .STAGGER_CYCLES(STAGGER),
        .RESET_ATTR(RATTR)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .cfg_valid_i(cfg_valid),
        .cfg_ready_o(cfg_ready),
        .cfg_attr_i(cfg_attr),
        .cfg_attr_we_i(cfg_we),
        .cfg_oe_mask_i(cfg_mask),
        .abort_i(abort),
        .pad_oe_o(pad_oe),
        .pad_attributes_o(pad_attr),
        .busy_o(busy),
        .done_o(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  oe;
        logic        done;
        logic        busy;
        logic        ready;
        logic [63:0] attr;
    } exp_t;

    typedef struct {
        logic [3:0]  mask;
        logic [3:0]  we;
        logic [15:0] attr;
    } req_t;

    exp_t        sb[$];
    req_t        tbl[4];
    int          n_vec = 0;
    int          n_err = 0;
    logic [3:0]  m_oe;
    logic [15:0] m_attr[4];

    function automatic logic [63:0] packed_attr();
        logic [63:0] v;
        for (int i = 0; i < NP; i++) v[i*PA +: PA] = m_attr[i];
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; cfg_valid = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_oe = '0;
        for (int i = 0; i < NP; i++) m_attr[i] = RATTR;
    endtask

    task automatic run_request(input req_t r, input bit hold, input req_t nxt);
        int         waited = 0;
        int         en[4];
        int         t;
        int         d = 0;
        int         dones = 0;
        logic [3:0] applied;
        exp_t       e;
        @(negedge clk);
        cfg_valid = 1'b1; cfg_mask = r.mask; cfg_we = r.we; cfg_attr = r.attr;
        while (!cfg_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!cfg_ready) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: ready stayed 0, expected 1");
            cfg_valid = 1'b0;
            return;
        end
        @(posedge clk);
        // E0: build expectations from the documented timeline
        applied = m_oe & r.mask;
        for (int i = 0; i < NP; i++) begin
            en[i] = -1;
            if (r.we[i]) m_attr[i] = r.attr;
        end
        t = SETTLE + 2;
`ifdef PAD_OE_STAGGER_EN
        for (int i = 0; i < NP; i++) begin
            if (r.mask[i] && !applied[i]) begin
                en[i] = t;
                if (i == NP - 1) d = t + STAGGER; else t += STAGGER + 1;
            end else begin
                if (i == NP - 1) d = t; else t += 1;
            end
        end
`else
        for (int i = 0; i < NP; i++) if (r.mask[i] && !applied[i]) en[i] = t;
        d = t;
`endif
        for (int k = 1; k <= d + 1; k++) begin
            e.oe = applied;
            for (int i = 0; i < NP; i++) if (en[i] >= 0 && en[i] <= k) e.oe[i] = 1'b1;
            e.done  = (k == d);
            e.busy  = (k <= d);
            e.ready = (k > d);
            e.attr  = packed_attr();
            sb.push_back(e);
        end
        m_oe = applied | r.mask;
        #1;
        if (hold) begin
            cfg_mask = nxt.mask; cfg_we = nxt.we; cfg_attr = nxt.attr;
        end else begin
            cfg_valid = 1'b0;
        end
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check("pad_oe", 64'(pad_oe), 64'(e.oe));
            check("done", 64'(done), 64'(e.done));
            check("busy", 64'(busy), 64'(e.busy));
            check("ready", 64'(cfg_ready), 64'(e.ready));
            check("attributes", pad_attr, e.attr);
            dones += int'(done);
        end
        check("done_pulses", 64'(dones), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   abort_edge;
        int   dones;
        req_t ra, rb;

        tbl[0] = '{mask: 4'b0101, we: 4'b1111, attr: 16'h00A5};
        tbl[1] = '{mask: 4'b1111, we: 4'b0011, attr: 16'h1234};
        tbl[2] = '{mask: 4'b0011, we: 4'b0000, attr: 16'h0000};
        tbl[3] = '{mask: 4'b1010, we: 4'b1000, attr: 16'hBEEF};

        rst = 1'b1; cfg_valid = 1'b0; abort = 1'b0;
        cfg_attr = '0; cfg_we = '0; cfg_mask = '0;
        do_reset();
        #1;
        check("reset_oe", 64'(pad_oe), 64'd0);
        check("reset_attr", pad_attr, packed_attr());
        check("reset_ready", 64'(cfg_ready), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);

        for (int v = 0; v < 4; v++) run_request(tbl[v], 1'b0, tbl[v]);

        // abort coincident with acceptance: request dropped, pads forced off
        @(negedge clk);
        cfg_valid = 1'b1; abort = 1'b1; cfg_mask = 4'b1111; cfg_we = 4'b1111; cfg_attr = 16'h9999;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0; abort = 1'b0;
        m_oe = '0;
        check("coinc_abort_oe", 64'(pad_oe), 64'd0);
        check("coinc_abort_busy", 64'(busy), 64'd0);
        check("coinc_abort_attr", pad_attr, packed_attr());
        @(posedge clk);
        #1;
        check("coinc_abort_idle", 64'(busy), 64'd0);

        // valid held while busy: second request only after done
        ra = '{mask: 4'b0110, we: 4'b0110, attr: 16'h4242};
        rb = '{mask: 4'b1001, we: 4'b1001, attr: 16'h1818};
        run_request(ra, 1'b1, rb);
        run_request(rb, 1'b0, rb);

        // reset asserted during SETTLE
        @(negedge clk);
        cfg_valid = 1'b1; cfg_mask = 4'b1111; cfg_we = 4'b1111; cfg_attr = 16'h6666;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) m_attr[i] = RATTR;
        m_oe = '0;
        check("settle_rst_oe", 64'(pad_oe), 64'd0);
        check("settle_rst_attr", pad_attr, packed_attr());
        check("settle_rst_busy", 64'(busy), 64'd0);
        check("settle_rst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("settle_rst_ready", 64'(cfg_ready), 64'd1);

        // abort mid-sequence (WAIT after pad0 when staggered, SETTLE otherwise)
`ifdef PAD_OE_STAGGER_EN
        abort_edge = 6;
`else
        abort_edge = 2;
`endif
        @(negedge clk);
        cfg_valid = 1'b1; cfg_mask = 4'b0101; cfg_we = 4'b0001; cfg_attr = 16'h7777;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        m_attr[0] = 16'h7777;
        for (int k = 1; k < abort_edge; k++) begin
            @(posedge clk);
            #1;
        end
`ifdef PAD_OE_STAGGER_EN
        check("pre_abort_oe", 64'(pad_oe), 64'd1);
`else
        check("pre_abort_oe", 64'(pad_oe), 64'd0);
`endif
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        m_oe = '0;
        check("abort_oe", 64'(pad_oe), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ready", 64'(cfg_ready), 64'd1);
        check("abort_attr", pad_attr, packed_attr());
        dones = int'(done);
        @(negedge clk);
        abort = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            dones += int'(done);
        end
        check("abort_no_done", 64'(dones), 64'd0);
        check("abort_stays_idle", 64'(busy), 64'd0);

        // from all-off, mask 1011 (single-edge enable in the unstaggered build)
        do_reset();
        rb = '{mask: 4'b1011, we: 4'b0000, attr: 16'h0000};
        run_request(rb, 1'b0, rb);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
